// File: rtl/result_bcd_conv_if.sv
// Product/BCD handshake bundle between the multiplier output stage, the
// BCD converter and the seven-segment driver.
interface result_bcd_conv_if #(
  parameter int IN_W  = 16,
  parameter int N_DIG = 5
);
  logic [IN_W-1:0]    result;
  logic               done;
  logic               sign;
  logic [4*N_DIG-1:0] bcd;
  logic               bcd_valid;
  logic               busy;

  // master: product source / digit consumer; slave: the converter
  modport master (
    output result,
    output done,
    input  sign,
    input  bcd,
    input  bcd_valid,
    input  busy
  );

  modport slave (
    input  result,
    input  done,
    output sign,
    output bcd,
    output bcd_valid,
    output busy
  );
endinterface

// File: rtl/result_bcd_conv.sv
// Sequential signed binary-to-BCD converter (double-dabble, one bit per cycle)
// triggered by the rising edge of the multiplier's done flag.
module result_bcd_conv #(
  parameter int IN_W  = 16,
  parameter int N_DIG = 5
) (
  input  logic             clk,
  input  logic             rst,
  result_bcd_conv_if.slave bus
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [IN_W-1:0]    mag_q, mag_d;
  logic               sgn_q, sgn_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic               busy_q, busy_d;

  logic               start;
  logic               abort;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   shifted;

  assign start = bus.done & ~done_q;
  assign abort = ~bus.done & done_q;

  // Add-3 correction on every digit that would overflow past 9 after doubling
  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                              (scratch_q[4*gi +: 4] + 4'd3) :
                              scratch_q[4*gi +: 4];
    end
  endgenerate

  assign shifted = (adj << 1) | BCD_W'(mag_q[IN_W-1]);

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      scratch_q   <= '0;
      mag_q       <= '0;
      sgn_q       <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= bus.done;
      cnt_q       <= cnt_d;
      scratch_q   <= scratch_d;
      mag_q       <= mag_d;
      sgn_q       <= sgn_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; abort takes priority over any other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (abort)                  state_d = IDLE;
        else if (cnt_q == LAST_CNT) state_d = HOLD;
      end
      HOLD: begin
        if (abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d       = cnt_q;
    scratch_d   = scratch_q;
    mag_d       = mag_q;
    sgn_d       = sgn_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    bcd_valid_d = bcd_valid_q;

    if (abort) begin
      bcd_d       = '0;
      sign_d      = 1'b0;
      bcd_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Negation wraps in IN_W bits, so the most negative input yields 2^(IN_W-1)
          mag_d     = bus.result[IN_W-1] ? (~bus.result + IN_W'(1)) : bus.result;
          sgn_d     = bus.result[IN_W-1];
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        if (!abort) begin
          scratch_d = shifted;
          mag_d     = mag_q << 1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            bcd_d       = shifted;
            sign_d      = sgn_q;
            bcd_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
      end
      default: begin
      end
    endcase
  end

  assign busy_d = (state_d == SHIFT);

  assign bus.sign      = sign_q;
  assign bus.bcd       = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Scoreboard bench for result_bcd_conv: expected digits are queued when a
// product is presented and compared when bcd_valid rises.
module tb_result_bcd_conv;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [20:0] exp_q[$];

  result_bcd_conv_if #(.IN_W(16), .N_DIG(5)) bus ();

  result_bcd_conv #(.IN_W(16), .N_DIG(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: {sign, five BCD digits} of a signed 16-bit value
  function automatic logic [20:0] model(input int v);
    int          m;
    logic [19:0] d;
    m = (v < 0) ? -v : v;
    for (int k = 0; k < 5; k++) begin
      d[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {(v < 0), d};
  endfunction

  // Present a product at a falling edge; optionally queue its expected result
  task automatic start_op(input int v, input bit push);
    @(negedge clk);
    bus.result = 16'(v);
    bus.done   = 1'b1;
    if (push) exp_q.push_back(model(v));
    $display("txn start result=%0d", v);
  endtask

  // Wait (bounded) for bcd_valid, counting negedges and cycles with busy high
  task automatic wait_valid(output int cycles, output int busy_cnt, output bit timeout);
    cycles   = 0;
    busy_cnt = 0;
    while (!bus.bcd_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (bus.busy) busy_cnt++;
    end
    timeout = !bus.bcd_valid;
  endtask

  task automatic test_reset();
    int cyc, bc; bit to;
    logic [20:0] exp_v;
    rst = 1'b0;
    bus.done = 1'b1;
    bus.result = 16'h7FFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sign, bus.bcd, bus.bcd_valid, bus.busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.sign, bus.bcd, bus.bcd_valid, bus.busy});
    end
    exp_q.push_back(model(32767));
    rst = 1'b1;
    wait_valid(cyc, bc, to);
    checks++;
    if (to || cyc != 17) begin
      errors++;
      $display("FAIL reset_release_latency got=%0d exp=17 timeout=%0b", cyc, to);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if ({bus.sign, bus.bcd} !== exp_v) begin
      errors++;
      $display("FAIL reset_release_value got=%h exp=%h", {bus.sign, bus.bcd}, exp_v);
    end
    $display("txn reset_release bcd=%h sign=%0b", bus.bcd, bus.sign);
    bus.done = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.bcd_valid, bus.bcd, bus.sign} !== 22'd0) begin
      errors++;
      $display("FAIL reset_abort_clear got=%h exp=0", {bus.bcd_valid, bus.bcd, bus.sign});
    end
  endtask

  task automatic test_positive();
    int cyc, bc, unstable; bit to;
    logic [20:0] exp_v;
    start_op(1234, 1'b1);
    wait_valid(cyc, bc, to);
    checks++;
    if (to || bc != 16) begin
      errors++;
      $display("FAIL pos_busy_cycles got=%0d exp=16 timeout=%0b", bc, to);
    end
    checks++;
    if (cyc != 17) begin
      errors++;
      $display("FAIL pos_latency got=%0d exp=17", cyc);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if ({bus.sign, bus.bcd} !== exp_v) begin
      errors++;
      $display("FAIL pos_value got=%h exp=%h", {bus.sign, bus.bcd}, exp_v);
    end
    $display("txn pos bcd=%h sign=%0b", bus.bcd, bus.sign);
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({bus.sign, bus.bcd, bus.bcd_valid, bus.busy} !== {exp_v, 1'b1, 1'b0}) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL pos_hold unstable_cycles=%0d exp=0", unstable);
    end
    bus.done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_negative();
    int vals[3] = '{-32768, -1, 0};
    int cyc, bc; bit to;
    logic [20:0] exp_v;
    foreach (vals[i]) begin
      start_op(vals[i], 1'b1);
      wait_valid(cyc, bc, to);
      exp_v = exp_q.pop_front();
      checks++;
      if (to || {bus.sign, bus.bcd} !== exp_v) begin
        errors++;
        $display("FAIL neg_value[%0d] got=%h exp=%h timeout=%0b", vals[i], {bus.sign, bus.bcd}, exp_v, to);
      end
      $display("txn neg result=%0d bcd=%h sign=%0b", vals[i], bus.bcd, bus.sign);
      bus.done = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.bcd_valid, bus.sign, bus.bcd} !== 22'd0) begin
        errors++;
        $display("FAIL neg_clear[%0d] got=%h exp=0", vals[i], {bus.bcd_valid, bus.sign, bus.bcd});
      end
    end
  endtask

  task automatic test_abort();
    int cyc, bc, late; bit to;
    logic [20:0] exp_v;
    start_op(999, 1'b0);
    repeat (7) @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.bcd_valid, bus.bcd} !== 22'd0) begin
      errors++;
      $display("FAIL abort_clear got=%h exp=0", {bus.busy, bus.bcd_valid, bus.bcd});
    end
    late = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.bcd_valid || bus.busy) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL abort_stays_idle active_cycles=%0d exp=0", late);
    end
    $display("txn abort result=999");
    start_op(-45, 1'b1);
    wait_valid(cyc, bc, to);
    exp_v = exp_q.pop_front();
    checks++;
    if (to || {bus.sign, bus.bcd} !== exp_v) begin
      errors++;
      $display("FAIL abort_next got=%h exp=%h timeout=%0b", {bus.sign, bus.bcd}, exp_v, to);
    end
    $display("txn after_abort bcd=%h sign=%0b", bus.bcd, bus.sign);
    bus.done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, bc; bit to;
    logic [20:0] exp_v;
    start_op(100, 1'b1);
    wait_valid(cyc, bc, to);
    exp_v = exp_q.pop_front();
    checks++;
    if (to || {bus.sign, bus.bcd} !== exp_v) begin
      errors++;
      $display("FAIL b2b_first got=%h exp=%h timeout=%0b", {bus.sign, bus.bcd}, exp_v, to);
    end
    $display("txn b2b_first bcd=%h sign=%0b", bus.bcd, bus.sign);
    bus.done = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_clear got=%0b exp=0", bus.bcd_valid);
    end
    bus.result = 16'(-200);
    bus.done = 1'b1;
    exp_q.push_back(model(-200));
    wait_valid(cyc, bc, to);
    exp_v = exp_q.pop_front();
    checks++;
    if (to || cyc != 17 || {bus.sign, bus.bcd} !== exp_v) begin
      errors++;
      $display("FAIL b2b_second got=%h exp=%h cycles=%0d timeout=%0b", {bus.sign, bus.bcd}, exp_v, cyc, to);
    end
    $display("txn b2b_second bcd=%h sign=%0b", bus.bcd, bus.sign);
    bus.done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_result_toggle();
    int cyc;
    logic [20:0] exp_v;
    start_op(4321, 1'b1);
    cyc = 0;
    while (!bus.bcd_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.result = 16'($urandom);
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (!bus.bcd_valid || {bus.sign, bus.bcd} !== exp_v) begin
      errors++;
      $display("FAIL toggle_value got=%h exp=%h valid=%0b", {bus.sign, bus.bcd}, exp_v, bus.bcd_valid);
    end
    $display("txn toggle bcd=%h sign=%0b", bus.bcd, bus.sign);
    bus.done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int active, cyc, bc; bit to;
    // Mid-SHIFT reset
    start_op(5555, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.bcd_valid, bus.sign, bus.bcd} !== 23'd0) begin
      errors++;
      $display("FAIL async_rst_shift got=%h exp=0", {bus.busy, bus.bcd_valid, bus.sign, bus.bcd});
    end
    bus.done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    active = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy || bus.bcd_valid) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL async_rst_idle active_cycles=%0d exp=0", active);
    end
    $display("txn async_reset_shift result=5555");
    // Reset during HOLD clears held digits without a clock edge
    start_op(-9876, 1'b0);
    wait_valid(cyc, bc, to);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (to || {bus.bcd_valid, bus.sign, bus.bcd} !== 22'd0) begin
      errors++;
      $display("FAIL async_rst_hold got=%h exp=0 timeout=%0b", {bus.bcd_valid, bus.sign, bus.bcd}, to);
    end
    bus.done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("txn async_reset_hold result=-9876");
  endtask

  initial begin
    rst = 1'b0;
    bus.done = 1'b0;
    bus.result = '0;
    test_reset();
    test_positive();
    test_negative();
    test_abort();
    test_back_to_back();
    test_result_toggle();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
